// File: rtl/i2c_bus_monitor.sv
// rtl/i2c_bus_monitor.sv - per-channel I2C START/repeated START/STOP detector
// Synchronises and glitch-filters SCL/SDA, tracks bus busy and flags SCL-low hangs.
module i2c_bus_monitor #(
  parameter int CHANNELS       = 1,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 3,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic [CHANNELS-1:0] scl_i,
  input  logic [CHANNELS-1:0] sda_i,
  output logic [CHANNELS-1:0] start_o,
  output logic [CHANNELS-1:0] rstart_o,
  output logic [CHANNELS-1:0] stop_o,
  output logic [CHANNELS-1:0] timeout_o,
  output logic [CHANNELS-1:0] busy_o,
  output logic [CHANNELS-1:0] scl_f_o,
  output logic [CHANNELS-1:0] sda_f_o
);
  localparam int FCW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam int TCW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [FCW-1:0] FC_LAST = FCW'(FILTER_CYCLES - 1);
  localparam logic [TCW-1:0] TO_LAST = TO_EN ? TCW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} bus_state_t;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [1:0]             raw;
    logic [SYNC_STAGES-1:0] sync_q [2];
    logic [FCW-1:0]         cnt_q  [2];
    logic [1:0]             f_q, fq_q;   // bit 0 = SCL, bit 1 = SDA
    logic                   armed_q;
    bus_state_t             state_q, state_d;
    logic [TCW-1:0]         tcnt_q, tcnt_d;
    logic                   start_c, stop_c, tmo_c;
    logic                   start_d, rstart_d, tmo_d;
    logic                   start_q, rstart_q, stop_q, tmo_q;

    assign raw = {sda_i[ch], scl_i[ch]};

    always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
        for (int ln = 0; ln < 2; ln++) begin
          sync_q[ln] <= '0;
          cnt_q[ln]  <= '0;
        end
        f_q     <= '0;
        fq_q    <= '0;
        armed_q <= 1'b0;
      end else begin
        for (int ln = 0; ln < 2; ln++) begin
          sync_q[ln] <= {sync_q[ln][SYNC_STAGES-2:0], raw[ln]};
          if (sync_q[ln][SYNC_STAGES-1] == f_q[ln]) begin
            cnt_q[ln] <= '0;
          end else if (cnt_q[ln] == FC_LAST) begin
            f_q[ln]   <= sync_q[ln][SYNC_STAGES-1];
            cnt_q[ln] <= '0;
          end else begin
            cnt_q[ln] <= cnt_q[ln] + FCW'(1);
          end
        end
        fq_q    <= f_q;
        armed_q <= armed_q | (f_q[0] & f_q[1]);
      end
    end

    // Both lines must be stably high across the SDA edge, so simultaneous edges never qualify.
    assign start_c = armed_q & f_q[0] & fq_q[0] & fq_q[1] & ~f_q[1];
    assign stop_c  = armed_q & f_q[0] & fq_q[0] & ~fq_q[1] & f_q[1];
    assign tmo_c   = TO_EN & (state_q == BUSY) & ~f_q[0] & (tcnt_q == TO_LAST);

    always_comb begin
      state_d  = state_q;
      start_d  = 1'b0;
      rstart_d = 1'b0;
      tmo_d    = 1'b0;
      tcnt_d   = tcnt_q + TCW'(1);
      if (!TO_EN || state_q == IDLE || f_q[0]) tcnt_d = '0;
      if (state_q == IDLE) begin
        if (start_c) begin
          start_d = 1'b1;
          state_d = BUSY;
        end
      end else begin
        if (start_c) begin
          rstart_d = 1'b1;
        end else if (stop_c) begin
          state_d = IDLE;
        end else if (tmo_c) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
          tcnt_d  = '0;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
        state_q  <= IDLE;
        tcnt_q   <= '0;
        start_q  <= 1'b0;
        rstart_q <= 1'b0;
        stop_q   <= 1'b0;
        tmo_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        tcnt_q   <= tcnt_d;
        start_q  <= start_d;
        rstart_q <= rstart_d;
        stop_q   <= stop_c;
        tmo_q    <= tmo_d;
      end
    end

    assign start_o[ch]   = start_q;
    assign rstart_o[ch]  = rstart_q;
    assign stop_o[ch]    = stop_q;
    assign timeout_o[ch] = tmo_q;
    assign busy_o[ch]    = (state_q == BUSY);
    assign scl_f_o[ch]   = f_q[0];
    assign sda_f_o[ch]   = f_q[1];
  end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// tb/tb_i2c_bus_monitor.sv - randomized and directed bench for i2c_bus_monitor
// Reference model: pin history delay line, "last N samples disagree" filter, event rules.
module tb_i2c_bus_monitor;
  localparam int CH = 2, SS = 2, FC = 3, TO = 100, HL = SS + FC - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [CH-1:0] scl, sda;
  logic [CH-1:0] start_o, rstart_o, stop_o, timeout_o, busy_o, scl_f_o, sda_f_o;
  int total = 0, bad = 0, cyc = 0;

  always #5 clk = ~clk;

  i2c_bus_monitor #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_CYCLES(FC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .scl_i(scl), .sda_i(sda),
    .start_o(start_o), .rstart_o(rstart_o), .stop_o(stop_o), .timeout_o(timeout_o),
    .busy_o(busy_o), .scl_f_o(scl_f_o), .sda_f_o(sda_f_o)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit hist [CH][2][HL];
  bit m_f [CH][2];
  bit m_fq [CH][2];
  bit m_armed [CH];
  bit m_busy [CH];
  int m_low [CH];
  bit e_st [CH], e_rs [CH], e_sp [CH], e_to [CH];
  bit st, sp, tmo, flip;

  always @(posedge clk) begin
    cyc++;
    for (int c = 0; c < CH; c++) begin
      if (!reset_n) begin
        for (int l = 0; l < 2; l++) begin
          m_f[c][l] = 0; m_fq[c][l] = 0;
          for (int k = 0; k < HL; k++) hist[c][l][k] = 0;
        end
        m_armed[c] = 0; m_busy[c] = 0; m_low[c] = 0;
        e_st[c] = 0; e_rs[c] = 0; e_sp[c] = 0; e_to[c] = 0;
      end else begin
        st  = m_armed[c] & m_f[c][0] & m_fq[c][0] & m_fq[c][1] & !m_f[c][1];
        sp  = m_armed[c] & m_f[c][0] & m_fq[c][0] & !m_fq[c][1] & m_f[c][1];
        tmo = m_busy[c] && !m_f[c][0] && (m_low[c] == TO - 1);
        e_st[c] = st & !m_busy[c];
        e_rs[c] = st & m_busy[c];
        e_sp[c] = sp;
        e_to[c] = tmo & !sp;
        m_low[c] = (m_busy[c] && !m_f[c][0] && !tmo) ? m_low[c] + 1 : 0;
        if (st) m_busy[c] = 1;
        else if (sp || tmo) m_busy[c] = 0;
        m_armed[c] = m_armed[c] | (m_f[c][0] & m_f[c][1]);
        for (int l = 0; l < 2; l++) begin
          flip = 1;
          for (int k = 0; k < FC; k++) if (hist[c][l][SS-1+k] == m_f[c][l]) flip = 0;
          m_fq[c][l] = m_f[c][l];
          if (flip) m_f[c][l] = !m_f[c][l];
          for (int k = HL - 1; k > 0; k--) hist[c][l][k] = hist[c][l][k-1];
          hist[c][l][0] = (l == 0) ? scl[c] : sda[c];
        end
      end
    end
  end

  // Per-cycle comparison plus event bookkeeping for directed checks
  int n_st [CH], n_rs [CH], n_sp [CH], n_to [CH];
  int last_st, last_to;
  bit sda_lo [CH];

  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      check($sformatf("out_ch%0d", c),
            {start_o[c], rstart_o[c], stop_o[c], timeout_o[c], busy_o[c], scl_f_o[c], sda_f_o[c]},
            {e_st[c], e_rs[c], e_sp[c], e_to[c], m_busy[c], m_f[c][0], m_f[c][1]});
      n_st[c] += int'(start_o[c]);
      n_rs[c] += int'(rstart_o[c]);
      n_sp[c] += int'(stop_o[c]);
      n_to[c] += int'(timeout_o[c]);
      if (sda_f_o[c] === 1'b0) sda_lo[c] = 1;
    end
    if (start_o[0] === 1'b1) last_st = cyc;
    if (timeout_o[0] === 1'b1) last_to = cyc;
  end

  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clr();
    for (int c = 0; c < CH; c++) begin
      n_st[c] = 0; n_rs[c] = 0; n_sp[c] = 0; n_to[c] = 0; sda_lo[c] = 0;
    end
  endtask

  task automatic do_start(int c);
    sda[c] = 1'b0; tick(10);
  endtask

  task automatic do_bits(int c, int n);
    for (int i = 0; i < n; i++) begin
      scl[c] = 1'b0; tick(4);
      sda[c] = 1'($urandom_range(0, 1)); tick(4);
      scl[c] = 1'b1; tick(6);
    end
  endtask

  task automatic do_stop(int c);
    scl[c] = 1'b0; tick(4);
    sda[c] = 1'b0; tick(4);
    scl[c] = 1'b1; tick(6);
    sda[c] = 1'b1; tick(10);
  endtask

  task automatic do_rstart(int c);
    scl[c] = 1'b0; tick(4);
    sda[c] = 1'b1; tick(4);
    scl[c] = 1'b1; tick(6);
    sda[c] = 1'b0; tick(10);
  endtask

  int c0, hold [CH], r;

  initial begin
    scl = '1; sda = '1; reset_n = 1'b0;
    clr();
    tick(4);
    check("rst_outs", {start_o, rstart_o, stop_o, timeout_o, busy_o, scl_f_o, sda_f_o}, 0);
    reset_n = 1'b1; tick(10);
    check("arm_quiet", n_st[0] + n_rs[0] + n_sp[0] + n_to[0], 0);
    check("idle_lvls", {busy_o, scl_f_o, sda_f_o}, 6'b00_11_11);

    // Release reset with SDA low, then raise it: unarmed, so no STOP
    reset_n = 1'b0; sda[0] = 1'b0; tick(3);
    reset_n = 1'b1; tick(8);
    clr(); sda[0] = 1'b1; tick(10);
    check("sda_low_rel", n_sp[0] + n_st[0], 0);

    // START / bits / STOP on channel 0 with latency
    clr(); c0 = cyc; sda[0] = 1'b0; tick(10);
    check("start_lat", last_st - c0, 6);
    check("start_cnt", n_st[0], 1);
    check("start_busy", busy_o, 2'b01);
    do_bits(0, 9); do_stop(0);
    check("stop_cnt", n_sp[0], 1);
    check("stop_busy", busy_o, 2'b00);
    check("ch1_quiet", n_st[1] + n_rs[1] + n_sp[1] + n_to[1], 0);

    // Repeated START
    clr(); do_start(0); do_bits(0, 9); do_rstart(0);
    check("rs_cnt", n_rs[0], 1);
    check("rs_start", n_st[0], 1);
    check("rs_busy", busy_o[0], 1);
    do_stop(0);

    // Glitch rejection: 2 samples filtered, 3 pass
    clr(); sda[0] = 1'b0; tick(2); sda[0] = 1'b1; tick(10);
    check("glitch2_st", n_st[0], 0);
    check("glitch2_f", sda_lo[0], 0);
    clr(); sda[0] = 1'b0; tick(3); sda[0] = 1'b1; tick(10);
    check("glitch3_st", n_st[0], 1);
    check("glitch3_sp", n_sp[0], 1);

    // Timeout after exactly 100 SCL-low cycles
    clr(); do_start(0);
    c0 = cyc; scl[0] = 1'b0; tick(100); scl[0] = 1'b1; tick(10);
    check("to_cnt", n_to[0], 1);
    check("to_lat", last_to - c0, 105);
    check("to_busy", busy_o[0], 0);
    sda[0] = 1'b1; tick(10);
    clr(); do_start(0);
    scl[0] = 1'b0; tick(99); scl[0] = 1'b1; tick(10);
    check("to99_cnt", n_to[0], 0);
    check("to99_busy", busy_o[0], 1);
    do_stop(0);

    // Simultaneous SCL/SDA edges
    clr(); scl[0] = 1'b0; sda[0] = 1'b0; tick(10); scl[0] = 1'b1; sda[0] = 1'b1; tick(10);
    check("simul", n_st[0] + n_sp[0] + n_rs[0], 0);

    // Reset mid-transaction
    do_start(0);
    reset_n = 1'b0; tick(1);
    check("midrst_outs", {start_o, rstart_o, stop_o, timeout_o, busy_o, scl_f_o, sda_f_o}, 0);
    sda[0] = 1'b1; tick(3); reset_n = 1'b1; tick(10);
    clr(); do_start(0);
    check("rearm_st", n_st[0], 1);
    check("rearm_rs", n_rs[0], 0);
    do_stop(0);

    // Randomized traffic on both channels, checked every cycle against the model
    for (int c = 0; c < CH; c++) hold[c] = 0;
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          r = int'($urandom_range(0, 9));
          if (r < 4) sda[c] = ~sda[c];
          else if (r < 8) scl[c] = ~scl[c];
          else if (r == 8) begin scl[c] = ~scl[c]; sda[c] = ~sda[c]; end
          else scl[c] = 1'b0;
          hold[c] = (r == 9) ? int'($urandom_range(95, 105)) : int'($urandom_range(1, 6));
        end
        hold[c]--;
      end
      tick(1);
    end
    scl = '1; sda = '1; tick(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_bus_monitor.md
# i2c_bus_monitor

Multi-channel, parametrised I2C bus-condition detector for the CPLD I2C path. Per channel it synchronises and glitch-filters SCL/SDA, then reports START, repeated START and STOP conditions, tracks bus-busy state, and flags SCL-low bus hangs with a timeout. Its outputs feed the I2C slave shift/address logic, which also uses the filtered SCL/SDA.

## Interface
- CHANNELS, 1: number of independent I2C buses monitored (≥1).
- SYNC_STAGES, 2: synchroniser flops per input line (≥2).
- FILTER_CYCLES, 3: consecutive differing samples required before a filtered line changes (≥1; 1 means no filtering).
- TIMEOUT_CYCLES, 0: SCL-low limit while busy; 0 disables timeout, otherwise ≥2. Counter width is $clog2(TIMEOUT_CYCLES+1).

- clk_i  in  1  system clock; every flop is clocked on its rising edge.
- reset_n_i  in  1  synchronous, active-low reset.
- scl_i  in  CHANNELS  raw SCL pins, asynchronous.
- sda_i  in  CHANNELS  raw SDA pins, asynchronous.
- start_o  out  CHANNELS  one-cycle pulse: START with the bus idle.
- rstart_o  out  CHANNELS  one-cycle pulse: repeated START with the bus busy.
- stop_o  out  CHANNELS  one-cycle pulse: STOP.
- timeout_o  out  CHANNELS  one-cycle pulse: SCL held low for TIMEOUT_CYCLES while busy.
- busy_o  out  CHANNELS  level: a transaction is in progress.
- scl_f_o  out  CHANNELS  filtered SCL.
- sda_f_o  out  CHANNELS  filtered SDA.

## Operation
Channels are fully independent. Per channel, per line:
- Synchroniser: a chain of SYNC_STAGES flops, all reset to 0. Its output is s.
- Filter: filtered level f and counter cnt.
  - If s == f: cnt <= 0.
  - Else if cnt == FILTER_CYCLES-1: f <= s and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Reset: f = 0, cnt = 0. scl_f_o and sda_f_o are f.
- Delay: fq <= f each cycle; reset 0.

Arming, to suppress false conditions after reset:
- armed <= armed | (fscl & fsda); reset 0.
- All detection below uses the registered armed value.

Detection (combinational, registered into the output flops):
- START condition: armed & fscl & fsclq & fsdaq & ~fsda.
- STOP condition: armed & fscl & fsclq & ~fsdaq & fsda.
- If SCL and SDA change in the same filtered cycle (fsclq ≠ fscl), no condition is reported.

Bus state, one flop per channel:
- IDLE (busy_o = 0): START → start_o, go to BUSY. STOP → stop_o pulses, stay IDLE.
- BUSY (busy_o = 1): START → rstart_o, stay BUSY; start_o stays 0. STOP → stop_o, go to IDLE. Timeout → timeout_o, go to IDLE.

Timeout (only when TIMEOUT_CYCLES > 0):
- tcnt clears when state is IDLE or fscl == 1.
- Otherwise tcnt increments.
- When tcnt == TIMEOUT_CYCLES-1 and fscl == 0: timeout_o pulses, busy clears, tcnt <= 0.
- A STOP and a timeout in the same cycle: STOP wins; no timeout_o.

## Timing
- Reset values: all outputs 0, including scl_f_o and sda_f_o. All internal state is 0. Reset mid-transaction drops busy and any pending pulse on the next edge.
- Latency: a pin change set up before edge 0 appears on f after edge SYNC_STAGES+FILTER_CYCLES-1. The resulting start_o, rstart_o or stop_o is high for exactly the cycle after edge SYNC_STAGES+FILTER_CYCLES. With defaults, that is after edge 5.
- busy_o changes on the same edge that asserts the causing pulse.
- Pulses are never wider than one cycle. Two conditions are at least 2 cycles apart because the filtered level must settle.
- Glitches shorter than FILTER_CYCLES samples at s never reach f.
- Timeout: timeout_o asserts TIMEOUT_CYCLES cycles after the first cycle with fscl = 0 in BUSY.

## Test plan
- Reset release with both pins held high: armed after the 5-cycle pipeline fill, no pulses, busy_o = 0. Repeat with SDA held low during release, then raised: no stop_o.
- START then STOP on channel 0 (CHANNELS = 2, defaults):
  - SDA falls with SCL high → start_o[0] pulses 1 cycle, exactly 5 edges after the pin change, and busy_o[0] = 1.
  - SCL/SDA bit traffic, then STOP → stop_o[0] pulse, busy_o[0] = 0.
  - Channel 1 stays quiet throughout.
- Repeated START: START, 9 SCL clocks, then SDA falls with SCL high → rstart_o = 1 for 1 cycle, start_o = 0, busy stays 1.
- Glitch rejection: 2-cycle SDA low spike while SCL high and idle → no start_o, sda_f_o unchanged. A 3-cycle spike yields one start_o.
- Timeout (TIMEOUT_CYCLES = 100): START, then SCL held low 100 cycles → timeout_o pulses once, busy_o = 0. SCL low for only 99 cycles then released → no timeout_o.
- Simultaneous SCL and SDA edge, and reset asserted mid-transaction → no condition reported from the simultaneous edge. The reset case drives all outputs to 0 on the next edge, and the first condition after re-arm is reported as start_o, not rstart_o.
